// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, hides the 1-cycle instruction-memory read
// latency behind a one-entry skid buffer, and doubles as the program-load path in IDLE.
// Optional HALT-opcode detection is built when FETCH_HALT_DETECT_EN is defined.
module fetch_unit #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 19,
  parameter int OPC_W  = 5,
  parameter logic [OPC_W-1:0] HALT_OPCODE = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef FETCH_HALT_DETECT_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] pc, inflight_pc, skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              inflight, skid_valid;

  logic       xfer, out_free, redir, stop_run, halt_hit, flush, launch, issue;
  logic [1:0] occ;

  assign xfer     = ins_valid & ins_ready;
  assign out_free = ~ins_valid | ins_ready;
  assign redir    = (state == RUN) & redirect_valid;
  assign stop_run = (state == RUN) & stop & ~redirect_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (state == RUN) & ~redirect_valid & ~stop & xfer &
                    (ins_out[DATA_W-1 -: OPC_W] == HALT_OPCODE);
  assign launch   = start & ~stop & ((state == IDLE) | (state == HALT));
`else
  assign halt_hit = 1'b0;
  assign launch   = start & ~stop & (state == IDLE);
`endif

  assign flush = redir | stop_run | halt_hit;

  // Entries already owned downstream of the PC, after this cycle's transfer.
  assign occ   = {1'b0, inflight} + {1'b0, ins_valid} + {1'b0, skid_valid} - {1'b0, xfer};
  assign issue = (state == RUN) & ~flush & (occ <= 2'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (launch) state_d = RUN;
      RUN: begin
        if (redirect_valid) state_d = RUN;
        else if (stop)      state_d = IDLE;
        else if (halt_hit)  state_d = state_t'(2'd2);
      end
`ifdef FETCH_HALT_DETECT_EN
      HALT: begin
        if (stop)        state_d = IDLE;
        else if (launch) state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
      ins_valid   <= 1'b0;
      ins_out     <= '0;
      ins_pc      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end
      if (launch) pc <= start_pc;

      if (flush) begin
        // Clearing the inflight tag discards the return that lands next cycle.
        ins_valid  <= 1'b0;
        skid_valid <= 1'b0;
        if (redir) pc <= redirect_pc;
      end else if (out_free) begin
        if (skid_valid) begin
          ins_valid  <= 1'b1;
          ins_out    <= skid_data;
          ins_pc     <= skid_pc;
          skid_valid <= inflight;
          skid_data  <= im_rdata;
          skid_pc    <= inflight_pc;
        end else begin
          ins_valid <= inflight;
          if (inflight) begin
            ins_out <= im_rdata;
            ins_pc  <= inflight_pc;
          end
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= im_rdata;
        skid_pc    <= inflight_pc;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign im_we    = (state == IDLE) & load_valid & ~rst;
  assign im_addr  = (state == IDLE) ? load_addr : pc;
  assign im_wdata = (state == IDLE) ? load_data : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 19-bit CPU instruction memory.
- Owns the PC, drives the memory address/write-enable/write-data, and absorbs the memory's 1-cycle registered read latency.
- Hands instructions to decode over a valid/ready handshake, and accepts branch redirects.
- In IDLE, also acts as the program-load path into instruction memory.

Parameters:
- ADDR_W, 19, PC and memory address width
- DATA_W, 19, instruction width
- OPC_W, 5, opcode field width (instruction bits [DATA_W-1 -: OPC_W])
- HALT_OPCODE, 5'b11111, opcode recognised as HALT (only used with the optional feature)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin fetching at start_pc
- start_pc  in  ADDR_W  first fetch address
- stop  in  1  pulse: abort fetching, return to IDLE
- load_valid  in  1  program-load write strobe (honoured in IDLE only)
- load_addr  in  ADDR_W  program-load address
- load_data  in  DATA_W  program-load word
- im_we  out  1  to memory write enable
- im_addr  out  ADDR_W  to memory address
- im_wdata  out  DATA_W  to memory write data
- im_rdata  in  DATA_W  from memory registered read data, valid 1 cycle after address when im_we=0
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  ADDR_W  redirect target
- ins_valid  out  1  instruction available to decode
- ins_ready  in  1  decode accepts
- ins_out  out  DATA_W  instruction
- ins_pc  out  ADDR_W  address of ins_out
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, pc=0, inflight=0, skid_valid=0, ins_valid=0, ins_out=0, ins_pc=0, busy=0.
  - im_we is combinational and therefore 0 during reset.
- States: IDLE, RUN, HALT (HALT is reachable only with the optional feature).
- IDLE:
  - im_we=load_valid, im_addr=load_addr, im_wdata=load_data (combinational pass-through).
  - start → RUN with pc<=start_pc. If start and load_valid arrive in the same cycle, the write completes and start is taken.
- RUN:
  - im_we=0, im_addr=pc, im_wdata=0.
  - load_valid is ignored.
  - A stop pulse flushes all entries and goes to IDLE; stop wins over start.
- Issue rule: issue when (inflight + ins_valid + skid_valid − (ins_valid & ins_ready)) ≤ 1.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1.
  - The PC wraps 2^ADDR_W−1 → 0.
- Return path: the cycle after an issue, im_rdata/inflight_pc go to the output register if it is empty or being consumed; otherwise they go to the one-entry skid buffer.
  - The skid buffer drains to the output before new returns.
  - Order is always preserved.
- Latency: start sampled at edge E0 → im_addr=start_pc after E0 → ins_valid=1 after E2.
  - Sustains 1 instruction/cycle while ins_ready=1.
- Handshake:
  - ins_out/ins_pc are held stable while ins_valid=1 and ins_ready=0.
  - A transfer occurs on ins_valid & ins_ready.
- Redirect (RUN only; ignored in IDLE/HALT):
  - Highest priority after rst.
  - A transfer in the same cycle completes.
  - inflight, skid and the output register are then cleared, and pc<=redirect_pc.
  - The next cycle issues redirect_pc.
  - A return that lands in the cycle after the redirect is discarded, because its inflight tag was cleared.
- stop or redirect mid-load is not possible, since loads occur only in IDLE.
- rst mid-RUN returns to the reset values at the next edge.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- With the macro: when an instruction whose opcode equals HALT_OPCODE is transferred to decode, state → HALT.
  - No further issue; inflight/skid are flushed.
  - The HALT instruction itself is delivered.
  - In HALT, start → RUN at start_pc and stop → IDLE.
- Without the macro: the HALT state and the opcode compare are not built; opcodes are not inspected and only stop leaves RUN.

Test Plan:
- Load in IDLE: load_valid with addr 0..3, data 19'h00011..19'h00014 → im_we=1, im_addr/im_wdata mirror the inputs each cycle.
- Stream: start, start_pc=0, ins_ready=1 → ins_valid rises 2 edges after start; ins_out=0x00011,0x00012,0x00013,0x00014 on consecutive cycles; ins_pc=0..3.
- Backpressure: ins_ready=0 for 5 cycles mid-stream → ins_out held, no instruction lost or duplicated, at most 2 buffered; on release the sequence resumes in order.
- Redirect: redirect_valid with redirect_pc=0x7FFFE while an instruction is inflight → no stale instruction delivered; the next ins_pc values are 0x7FFFE, 0x7FFFF, then 0x00000 (wrap).
- Reset/stop: rst asserted mid-stream → next cycle ins_valid=0, busy=0, pc=0; stop likewise returns to IDLE, and load_valid during RUN produces im_we=0.
- FETCH_HALT_DETECT_EN: word 2 = 19'h7C000 (opcode 11111) → words 0,1,2 delivered, then ins_valid stays 0 and state=HALT; without the macro, fetch continues to word 3.
